// File: rtl/gray_switch_capture.sv
// Gray-coded DIP-switch front end: 2-flop synchronizer, whole-vector debounce,
// registered commit strobe plus a multi-bit-change (Gray violation) flag.
//
// state  | meaning
// IDLE   | candidate equals committed word, waiting for a change on sync2
// SETTLE | candidate differs or is being re-qualified, counting stable cycles
module gray_switch_capture #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_i,
  output logic [WIDTH-1:0] gray_o,
  output logic             gray_valid_o,
  output logic             gray_err_o,
  output logic             gray_err_sticky_o
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("gray_switch_capture: DEBOUNCE_CYCLES must be >= 1");
  end

  // A single-cycle debounce still needs one counter bit to keep widths legal.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE, SETTLE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             sticky_q, sticky_d;

  logic restart;
  logic cnt_tc;
  logic multi_bit;

  assign restart   = (sync2_q != cand_q);
  assign cnt_tc    = (cnt_q == CNT_TC);
  assign multi_bit = ($countones(cand_q ^ gray_q) > 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      gray_q   <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cand_q   <= cand_d;
      gray_q   <= gray_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (restart) state_d = SETTLE;
      SETTLE:  if (!restart && cnt_tc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sync1_d  = sw_i;
    sync2_d  = sync1_q;
    cand_d   = cand_q;
    gray_d   = gray_q;
    cnt_d    = cnt_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    sticky_d = sticky_q;
    case (state_q)
      IDLE: begin
        if (restart) begin
          cand_d = sync2_q;
          cnt_d  = '0;
        end
      end
      SETTLE: begin
        if (restart) begin
          cand_d = sync2_q;
          cnt_d  = '0;
        end else if (cnt_tc) begin
          // A candidate equal to the committed word is a bounce back: drop silently.
          if (cand_q != gray_q) begin
            gray_d   = cand_q;
            valid_d  = 1'b1;
            err_d    = multi_bit;
            sticky_d = sticky_q | multi_bit;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: cnt_d = '0;
    endcase
  end

  assign gray_o            = gray_q;
  assign gray_valid_o      = valid_q;
  assign gray_err_o        = err_q;
  assign gray_err_sticky_o = sticky_q;

endmodule

// File: tb/tb_gray_switch_capture.sv
// Directed bench for gray_switch_capture (DEBOUNCE_CYCLES=4): stimulus pushes
// expected commits into a queue, a negedge monitor pops and checks each strobe.
module tb_gray_switch_capture;

  localparam int W   = 4;
  localparam int DEB = 4;
  localparam int LAT = DEB + 3;  // from change after edge n to commit edge n+DEB+3

  logic         clk;
  logic         rst_n;
  logic [W-1:0] sw_i;
  logic [W-1:0] gray_o;
  logic         gray_valid_o;
  logic         gray_err_o;
  logic         gray_err_sticky_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [W-1:0] gray;
    logic [W-1:0] bin;
    logic         err;
    int           at;
  } exp_t;

  exp_t sb[$];

  gray_switch_capture #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .sw_i              (sw_i),
    .gray_o            (gray_o),
    .gray_valid_o      (gray_valid_o),
    .gray_err_o        (gray_err_o),
    .gray_err_sticky_o (gray_err_sticky_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (gray_valid_o) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_strobe gray_o=%b cyc=%0d expected no strobe", gray_o, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (gray_o !== e.gray || gray_err_o !== e.err || cyc != e.at ||
            g2b(gray_o) !== e.bin) begin
          bad++;
          $display("FAIL commit gray_o=%b err=%b bin=%0d cyc=%0d want gray=%b err=%b bin=%0d cyc=%0d",
                   gray_o, gray_err_o, g2b(gray_o), cyc, e.gray, e.err, e.bin, e.at);
        end
      end
    end else if (gray_err_o) begin
      total++;
      bad++;
      $display("FAIL err_without_valid gray_err_o=%b want 0 cyc=%0d", gray_err_o, cyc);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b cyc=%0d", name, act, want, cyc);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] g, input logic e);
    exp_t x;
    x.gray = g;
    x.bin  = g2b(g);
    x.err  = e;
    x.at   = cyc + LAT;
    sb.push_back(x);
  endtask

  // Holds reset for three edges, checks the cleared outputs, releases after an edge.
  task automatic do_reset(input logic [W-1:0] sw_val);
    sw_i  = sw_val;
    rst_n = 1'b0;
    wait_cyc(3);
    chk("rst_gray",   gray_o, '0);
    chk("rst_flags",  {1'b0, gray_valid_o, gray_err_o, gray_err_sticky_o}, '0);
    rst_n = 1'b1;
  endtask

  task automatic step(input logic [W-1:0] g, input logic e, input int hold);
    sw_i = g;
    push_exp(g, e);
    wait_cyc(hold);
  endtask

  initial begin
    logic [W-1:0] b;
    logic [W-1:0] g;
    rst_n = 1'b0;
    sw_i  = '0;
    @(negedge clk);

    // 1: reset with 1011 held, release -> 3-bit error commit
    do_reset(4'b1011);
    push_exp(4'b1011, 1'b1);
    wait_cyc(12);
    chk("t1_gray",   gray_o, 4'b1011);
    chk("t1_sticky", {3'b000, gray_err_sticky_o}, 4'b0001);

    // back to 0000 via reset, sticky must clear
    do_reset(4'b0000);
    wait_cyc(10);

    // 2: clean single-bit step
    step(4'b0001, 1'b0, 20);
    chk("t2_gray", gray_o, 4'b0001);

    // 3: bounce between 0011 and 0001, then settle on 0011
    for (int i = 0; i < 6; i++) begin
      sw_i = (i % 2 == 0) ? 4'b0011 : 4'b0001;
      wait_cyc(2);
    end
    step(4'b0011, 1'b0, 20);
    chk("t3_gray", gray_o, 4'b0011);

    // 4: glitch to 0111 and back: no strobe
    sw_i = 4'b0111;
    wait_cyc(2);
    sw_i = 4'b0011;
    wait_cyc(20);
    chk("t4_gray", gray_o, 4'b0011);

    // 5: full Gray walk from 0000, wrapping 1000 -> 0000
    do_reset(4'b0000);
    wait_cyc(10);
    for (int i = 1; i <= 16; i++) begin
      b = 4'(i % 16);
      g = b ^ (b >> 1);
      step(g, 1'b0, 10);
    end
    wait_cyc(5);
    chk("t5_gray",   gray_o, 4'b0000);
    chk("t5_sticky", {3'b000, gray_err_sticky_o}, 4'b0000);

    // 6: set sticky with a 2-bit jump, then reset mid-settle at cnt=2
    step(4'b0011, 1'b1, 12);
    chk("t6_sticky_set", {3'b000, gray_err_sticky_o}, 4'b0001);
    sw_i = 4'b0111;
    wait_cyc(5);
    do_reset(4'b0000);
    wait_cyc(20);
    chk("t6_gray",   gray_o, 4'b0000);
    chk("t6_sticky", {3'b000, gray_err_sticky_o}, 4'b0000);

    // every expected strobe must have been seen
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL missing_strobes pending=%0d want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gray_switch_capture.md
Name: gray_switch_capture

Overview:
Upstream input stage for the Gray-to-binary LED path. It samples the asynchronous 4-bit Gray-coded DIP-switch input and synchronizes it to clk. It debounces the whole vector, then presents a stable Gray word to the decoder, with a one-cycle update strobe and a Gray-code-violation flag (more than one bit changed between committed words).

Parameters:
WIDTH, 4, number of Gray-coded switch bits.
DEBOUNCE_CYCLES, 16, cycles the synchronized vector must hold unchanged before commit; legal range >= 1 (elaboration error otherwise).

Ports:
clk  input  1  system clock.
rst_n  input  1  synchronous, active-low reset.
sw_i  input  WIDTH  raw asynchronous switch inputs, Gray code.
gray_o  output  WIDTH  last committed stable Gray word; feeds the Gray-to-binary decoder.
gray_valid_o  output  1  one-cycle pulse on the cycle gray_o takes a new value.
gray_err_o  output  1  one-cycle pulse, coincident with gray_valid_o, when the commit differs from the previous gray_o in more than 1 bit.
gray_err_sticky_o  output  1  set by any gray_err_o pulse; cleared only by reset.

Behaviour:
- Interface: one clock, clk. Reset is rst_n, synchronous and active-low: sampled only on the rising edge of clk.
- Reset (rst_n=0 at a clk edge) forces:
  - sync1, sync2, cand, gray_o all 0;
  - cnt 0; state IDLE;
  - gray_valid_o, gray_err_o, gray_err_sticky_o all 0.
- Reset mid-settle discards the pending value; no strobe is produced.
- Synchronizer: two flops per bit, sync1 <= sw_i, sync2 <= sync1. No logic between the two stages.
- cnt width is $clog2(DEBOUNCE_CYCLES).
- FSM states: IDLE, SETTLE. All outputs are registered.
- IDLE (cand == gray_o):
  - If sync2 != cand: cand <= sync2, cnt <= 0, go to SETTLE.
  - Otherwise stay.
- SETTLE:
  - If sync2 != cand: cand <= sync2, cnt <= 0, stay (restart). This applies to every bounce.
  - Else if cnt == DEBOUNCE_CYCLES-1 and cand != gray_o: commit. gray_o <= cand, gray_valid_o <= 1, go to IDLE.
  - Else if cnt == DEBOUNCE_CYCLES-1 and cand == gray_o (input bounced back to the old value): go to IDLE, no strobe.
  - Else cnt <= cnt+1.
- Commit error check: gray_err_o <= (popcount(cand ^ gray_o) > 1). If set, gray_err_sticky_o <= 1. The value is still committed.
- gray_valid_o and gray_err_o are 0 on every cycle other than a commit. They never stay high for two consecutive cycles.
- Latency: let edge k be the first edge at which sync1 captures a new stable sw_i. Then gray_o and gray_valid_o update at edge k+DEBOUNCE_CYCLES+2.
- Minimum spacing between two strobes is DEBOUNCE_CYCLES+1 cycles.
- Wrap-around: the Gray transition 1000 -> 0000 is a legal single-bit change; no error.
- Simultaneous events: a sync2 change on the same edge cnt reaches terminal restarts the count; it does not commit.
- cnt saturates by construction; it never wraps.

Test Plan:
1. Reset behaviour: DEBOUNCE_CYCLES=4. Hold rst_n=0 for 3 cycles with sw_i=1011 -> gray_o=0000, all flags 0. Release reset; sw_i already 1011 and first sampled at edge 1 after release -> gray_o=1011, gray_valid_o=1 at edge 7 only, gray_err_o=1 (3 bits), sticky=1.
2. Clean single-bit step: from committed 0000, sw_i=0001 sampled at edge 10 -> gray_o=0001 and one-cycle valid at edge 16, err=0. No other valid pulse within 20 cycles.
3. Bounce: sw_i toggles 0001/0011 every 2 cycles for 12 cycles, then holds 0011 -> exactly one valid pulse, at 6 cycles after the first edge sampling the final 0011; gray_o=0011.
4. Glitch back: from committed 0011, sw_i=0111 for 2 cycles, then back to 0011 -> no valid pulse, gray_o stays 0011.
5. Gray walk and wrap: step through all 16 Gray codes ending 1000 -> 0000 -> 16 valid pulses, the decoder's binary output increments 0..15 then 0, err never asserted.
6. Mid-settle reset: sw_i change, assert rst_n=0 at cnt=2 -> gray_o=0 and no valid pulse. Sticky clears.
